// File: rtl/keyboard_pkg.sv
// keyboard_pkg: constants and helpers shared by the keyboard front end.
//   octave_e      : octave encodings OCT_LOW/OCT_MID/OCT_HIGH
//   NOTE_NONE     : note_code value when no note key is held
//   NUM_NOTE_KEYS : number of note keys
//   lowest_note() : priority encoder, lowest held key index + 1
package keyboard_pkg;

    typedef enum logic [1:0] {
        OCT_LOW  = 2'd0,
        OCT_MID  = 2'd1,
        OCT_HIGH = 2'd2
    } octave_e;

    localparam int unsigned NOTE_CODE_W   = 4;
    localparam logic [NOTE_CODE_W-1:0] NOTE_NONE = 4'd0;
    localparam int unsigned NUM_NOTE_KEYS = 7;

    // Lowest set bit wins; scanning from the top lets the lowest index overwrite.
    function automatic logic [NOTE_CODE_W-1:0] lowest_note(input logic [NUM_NOTE_KEYS-1:0] keys);
        logic [NOTE_CODE_W-1:0] code;
        code = NOTE_NONE;
        for (int i = NUM_NOTE_KEYS - 1; i >= 0; i--) begin
            if (keys[i]) code = NOTE_CODE_W'(i + 1);
        end
        return code;
    endfunction

endpackage

// File: rtl/debounce_cell.sv
// debounce_cell: 2-flop synchroniser followed by a hold-time debouncer.
//   clk    : system clock
//   reset  : asynchronous active-low reset
//   din    : raw asynchronous input
//   stable : debounced level
//   rise   : one-cycle pulse, high in the first cycle stable reads 1
module debounce_cell #(
    parameter int unsigned DEBOUNCE_CYCLES = 2_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic stable,
    output logic rise
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             meta_q;
    logic             sync_q;
    logic             stable_q, stable_d;
    logic             rise_q, rise_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Synchroniser
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= din;
            sync_q <= meta_q;
        end
    end

    // Any sample agreeing with the accepted level restarts the hold count.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        rise_d   = 1'b0;
        if (sync_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync_q;
                rise_d   = sync_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stable_q <= 1'b0;
            rise_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            stable_q <= stable_d;
            rise_q   <= rise_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable = stable_q;
    assign rise   = rise_q;

endmodule

// File: rtl/key_input_conditioner.sv
// key_input_conditioner: synchronises and debounces the raw board inputs and
// derives clean levels, press pulses, a note code and the octave register.
// Optional feature macro: KEY_AUTOREPEAT_EN (auto-repeat on next/prev).
//   clk, reset            : clock, asynchronous active-low reset
//   key_raw[6:0]          : raw note keys, bit0 = lowest note
//   octave_raw[1:0]       : raw octave keys, bit0 = down, bit1 = up
//   next_raw, prev_raw    : raw song-select buttons
//   key_level, key_press  : debounced note levels and one-cycle press pulses
//   note_code             : 0 = none, else lowest held key index + 1
//   octave                : 0 low, 1 middle, 2 high
//   next_pulse, prev_pulse: one-cycle song-select pulses
module key_input_conditioner
    import keyboard_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 2_000_000,
    parameter int unsigned REPEAT_DELAY    = 50_000_000,
    parameter int unsigned REPEAT_PERIOD   = 20_000_000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_NOTE_KEYS-1:0] key_raw,
    input  logic [1:0]               octave_raw,
    input  logic                     next_raw,
    input  logic                     prev_raw,
    output logic [NUM_NOTE_KEYS-1:0] key_level,
    output logic [NUM_NOTE_KEYS-1:0] key_press,
    output logic [NOTE_CODE_W-1:0]   note_code,
    output logic [1:0]               octave,
    output logic                     next_pulse,
    output logic                     prev_pulse
);

    localparam int unsigned NUM_INPUTS = NUM_NOTE_KEYS + 4;
    localparam int unsigned IDX_DOWN   = NUM_NOTE_KEYS;
    localparam int unsigned IDX_UP     = NUM_NOTE_KEYS + 1;
    localparam int unsigned IDX_NEXT   = NUM_NOTE_KEYS + 2;
    localparam int unsigned IDX_PREV   = NUM_NOTE_KEYS + 3;

    logic [NUM_INPUTS-1:0] raw_all;
    logic [NUM_INPUTS-1:0] lvl;
    logic [NUM_INPUTS-1:0] rise;

    assign raw_all = {prev_raw, next_raw, octave_raw, key_raw};

    // One independent conditioner per raw input
    for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_cell
        debounce_cell #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_cell (
            .clk    (clk),
            .reset  (reset),
            .din    (raw_all[g]),
            .stable (lvl[g]),
            .rise   (rise[g])
        );
    end

    assign key_level = lvl[NUM_NOTE_KEYS-1:0];
    assign key_press = rise[NUM_NOTE_KEYS-1:0];

    // Note code, one cycle behind key_level
    logic [NOTE_CODE_W-1:0] note_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) note_q <= NOTE_NONE;
        else        note_q <= lowest_note(lvl[NUM_NOTE_KEYS-1:0]);
    end

    assign note_code = note_q;

    // Saturating octave register; simultaneous up and down cancel.
    octave_e oct_q;
    logic    oct_up;
    logic    oct_dn;

    assign oct_up = rise[IDX_UP];
    assign oct_dn = rise[IDX_DOWN];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            oct_q <= OCT_MID;
        end else begin
            case (oct_q)
                OCT_LOW:  if (oct_up && !oct_dn) oct_q <= OCT_MID;
                OCT_MID: begin
                    if (oct_up && !oct_dn)      oct_q <= OCT_HIGH;
                    else if (oct_dn && !oct_up) oct_q <= OCT_LOW;
                end
                OCT_HIGH: if (oct_dn && !oct_up) oct_q <= OCT_MID;
                default:  oct_q <= OCT_MID;
            endcase
        end
    end

    assign octave = oct_q;

    logic unused_lvl;

`ifdef KEY_AUTOREPEAT_EN
    localparam int unsigned REP_SPAN = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned REP_W    = $clog2(REP_SPAN + 1);
    localparam logic [REP_W-1:0] DELAY_LAST  = REP_W'(REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0] PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);

    logic [1:0] btn_lvl;
    logic [1:0] rep_pulse;

    assign btn_lvl = {lvl[IDX_PREV], lvl[IDX_NEXT]};

    // Repeat timer: counts held cycles, first the initial delay, then the period.
    for (genvar b = 0; b < 2; b++) begin : g_rep
        logic [REP_W-1:0] cnt_q, cnt_d;
        logic             period_q, period_d;
        logic             pulse_q, pulse_d;

        always_comb begin
            cnt_d    = '0;
            period_d = 1'b0;
            pulse_d  = 1'b0;
            if (btn_lvl[b]) begin
                if (cnt_q == (period_q ? PERIOD_LAST : DELAY_LAST)) begin
                    pulse_d  = 1'b1;
                    period_d = 1'b1;
                end else begin
                    cnt_d    = cnt_q + 1'b1;
                    period_d = period_q;
                end
            end
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                cnt_q    <= '0;
                period_q <= 1'b0;
                pulse_q  <= 1'b0;
            end else begin
                cnt_q    <= cnt_d;
                period_q <= period_d;
                pulse_q  <= pulse_d;
            end
        end

        assign rep_pulse[b] = pulse_q;
    end

    // Repeat pulses never coincide with the initial press pulse.
    assign next_pulse = rise[IDX_NEXT] | rep_pulse[0];
    assign prev_pulse = rise[IDX_PREV] | rep_pulse[1];
    assign unused_lvl = ^{lvl[IDX_UP], lvl[IDX_DOWN]};
`else
    localparam int unsigned UNUSED_REPEAT_CFG = REPEAT_DELAY + REPEAT_PERIOD;

    assign next_pulse = rise[IDX_NEXT];
    assign prev_pulse = rise[IDX_PREV];
    assign unused_lvl = ^lvl[IDX_PREV:IDX_DOWN];
`endif

endmodule

// File: tb/tb_key_input_conditioner.sv
// Bench for key_input_conditioner with DEBOUNCE_CYCLES=4, REPEAT_DELAY=20,
// REPEAT_PERIOD=8. Expected outputs come from a window-based reference model.
module tb_key_input_conditioner;

    localparam int D  = 4;
    localparam int RD = 20;
    localparam int RP = 8;
`ifdef KEY_AUTOREPEAT_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] key_raw = '0;
    logic [1:0] octave_raw = '0;
    logic       next_raw = 1'b0;
    logic       prev_raw = 1'b0;
    logic [6:0] key_level;
    logic [6:0] key_press;
    logic [3:0] note_code;
    logic [1:0] octave;
    logic       next_pulse;
    logic       prev_pulse;

    int n_tests = 0;
    int n_fail  = 0;

    key_input_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clk       (clk),
        .reset     (rst_n),
        .key_raw   (key_raw),
        .octave_raw(octave_raw),
        .next_raw  (next_raw),
        .prev_raw  (prev_raw),
        .key_level (key_level),
        .key_press (key_press),
        .note_code (note_code),
        .octave    (octave),
        .next_pulse(next_pulse),
        .prev_pulse(prev_pulse)
    );

    always #5 clk = ~clk;

    // Reference model: an input is accepted once its raw value, seen through the
    // two-cycle synchroniser delay, has held the new value for D straight samples.
    logic [10:0] m_raw;
    logic [10:0] m_hist [0:D];
    logic [10:0] m_lvl;
    logic [10:0] m_rise;
    logic [3:0]  m_note;
    logic [1:0]  m_oct;
    logic        m_np;
    logic        m_pp;
    int          m_hold [2];

    assign m_raw = {prev_raw, next_raw, octave_raw, key_raw};

    function automatic logic [3:0] lowest(input logic [6:0] k);
        for (int i = 0; i < 7; i++) if (k[i]) return 4'(i + 1);
        return 4'd0;
    endfunction

    always @(posedge clk or negedge rst_n) begin : model
        logic [10:0] all1;
        logic [10:0] all0;
        logic [10:0] nlvl;
        int          h;
        logic        rp;
        if (!rst_n) begin
            for (int j = 0; j <= D; j++) m_hist[j] <= '0;
            m_lvl     <= '0;
            m_rise    <= '0;
            m_note    <= '0;
            m_oct     <= 2'd1;
            m_np      <= 1'b0;
            m_pp      <= 1'b0;
            m_hold[0] <= 0;
            m_hold[1] <= 0;
        end else begin
            all1 = '1;
            all0 = '1;
            for (int j = 1; j <= D; j++) begin
                all1 = all1 & m_hist[j];
                all0 = all0 & ~m_hist[j];
            end
            nlvl = (m_lvl | all1) & ~all0;
            m_hist[0] <= m_raw;
            for (int j = 1; j <= D; j++) m_hist[j] <= m_hist[j-1];
            m_lvl  <= nlvl;
            m_rise <= nlvl & ~m_lvl;
            m_note <= lowest(m_lvl[6:0]);
            if (m_rise[8] && !m_rise[7] && m_oct < 2'd2)      m_oct <= 2'(m_oct + 1);
            else if (m_rise[7] && !m_rise[8] && m_oct > 2'd0) m_oct <= 2'(m_oct - 1);
            for (int b = 0; b < 2; b++) begin
                rp = 1'b0;
                if (nlvl[9+b] && !m_lvl[9+b]) begin
                    m_hold[b] <= 0;
                    rp = 1'b1;
                end else if (m_lvl[9+b]) begin
                    h = m_hold[b] + 1;
                    m_hold[b] <= h;
                    rp = AUTO && ((h == RD) || (h > RD && ((h - RD) % RP) == 0));
                end
                if (b == 0) m_np <= rp;
                else        m_pp <= rp;
            end
        end
    end

    logic [21:0] dut_vec;
    logic [21:0] mdl_vec;
    assign dut_vec = {key_level, key_press, note_code, octave, next_pulse, prev_pulse};
    assign mdl_vec = {m_lvl[6:0], m_rise[6:0], m_note, m_oct, m_np, m_pp};

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        {prev_raw, next_raw, octave_raw, key_raw} = 11'($urandom);
        repeat (3) begin
            @(negedge clk);
            n_tests++;
            if (dut_vec !== {7'd0, 7'd0, 4'd0, 2'd1, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL reset_values got=%h exp=%h", dut_vec, {7'd0, 7'd0, 4'd0, 2'd1, 1'b0, 1'b0});
            end
        end
        rst_n = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            n_tests++;
            if ({key_level, key_press, note_code, octave, next_pulse, prev_pulse} !== {7'd0, 7'd0, 4'd0, 2'd1, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL reset_quiet cyc=%0d got=%h exp=%h", c, dut_vec, {7'd0, 7'd0, 4'd0, 2'd1, 1'b0, 1'b0});
            end
        end
        {prev_raw, next_raw, octave_raw, key_raw} = '0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            n_tests++;
            if (dut_vec !== mdl_vec) begin
                n_fail++;
                $display("FAIL reset_model cyc=%0d got=%h exp=%h", c, dut_vec, mdl_vec);
            end
        end
    endtask

    task automatic test_clean_press();
        @(negedge clk);
        key_raw = 7'b0000100;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            n_tests++;
            if (key_press[2] !== (i == 6) || key_level[2] !== (i >= 6) || note_code !== ((i >= 7) ? 4'd3 : 4'd0)) begin
                n_fail++;
                $display("FAIL clean_press edge=%0d got press=%b level=%b note=%0d exp press=%b level=%b note=%0d",
                         i, key_press[2], key_level[2], note_code, (i == 6), (i >= 6), (i >= 7) ? 3 : 0);
            end
            n_tests++;
            if (dut_vec !== mdl_vec) begin
                n_fail++;
                $display("FAIL clean_model edge=%0d got=%h exp=%h", i, dut_vec, mdl_vec);
            end
        end
    endtask

    task automatic test_bounce();
        int presses;
        presses = 0;
        for (int seg = 0; seg < 10; seg++) begin
            key_raw[0] = (seg % 2 == 0);
            repeat (2) begin
                @(negedge clk);
                n_tests++;
                if (key_press[0] !== 1'b0 || dut_vec !== mdl_vec) begin
                    n_fail++;
                    $display("FAIL bounce_toggle seg=%0d got=%h exp=%h", seg, dut_vec, mdl_vec);
                end
            end
        end
        key_raw[0] = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (key_press[0] === 1'b1) presses++;
            n_tests++;
            if (key_press[0] !== (i == 6) || dut_vec !== mdl_vec) begin
                n_fail++;
                $display("FAIL bounce_settle edge=%0d got=%h exp=%h", i, dut_vec, mdl_vec);
            end
        end
        n_tests++;
        if (presses !== 1) begin
            n_fail++;
            $display("FAIL bounce_count got=%0d exp=1", presses);
        end
    endtask

    task automatic test_priority();
        logic [6:0] pat [4];
        logic [3:0] want [4];
        pat[0] = 7'b0000000; want[0] = 4'd0;
        pat[1] = 7'b1000010; want[1] = 4'd2;
        pat[2] = 7'b1000000; want[2] = 4'd7;
        pat[3] = 7'b0000000; want[3] = 4'd0;
        for (int p = 0; p < 4; p++) begin
            key_raw = pat[p];
            for (int c = 0; c < 10; c++) begin
                @(negedge clk);
                n_tests++;
                if (dut_vec !== mdl_vec) begin
                    n_fail++;
                    $display("FAIL priority_model step=%0d cyc=%0d got=%h exp=%h", p, c, dut_vec, mdl_vec);
                end
            end
            n_tests++;
            if (note_code !== want[p]) begin
                n_fail++;
                $display("FAIL priority_note step=%0d got=%0d exp=%0d", p, note_code, want[p]);
            end
        end
    endtask

    task automatic test_octave();
        logic [1:0] seq [10];
        int         exp_oct;
        @(negedge clk);
        rst_n = 1'b0;
        {prev_raw, next_raw, octave_raw, key_raw} = '0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_oct = 1;
        for (int i = 0; i < 3; i++) seq[i] = 2'b10;
        for (int i = 3; i < 7; i++) seq[i] = 2'b01;
        seq[7] = 2'b10;
        seq[8] = 2'b11;
        seq[9] = 2'b11;
        for (int p = 0; p < 10; p++) begin
            octave_raw = seq[p];
            for (int c = 0; c < 16; c++) begin
                if (c == 8) octave_raw = 2'b00;
                @(negedge clk);
                n_tests++;
                if (dut_vec !== mdl_vec) begin
                    n_fail++;
                    $display("FAIL octave_model press=%0d cyc=%0d got=%h exp=%h", p, c, dut_vec, mdl_vec);
                end
            end
            if (seq[p] == 2'b10 && exp_oct < 2) exp_oct++;
            if (seq[p] == 2'b01 && exp_oct > 0) exp_oct--;
            n_tests++;
            if (octave !== 2'(exp_oct)) begin
                n_fail++;
                $display("FAIL octave_value press=%0d got=%0d exp=%0d", p, octave, exp_oct);
            end
        end
    endtask

    task automatic test_autorepeat();
        int pq [$];
        int ex [$];
        int late;
        ex = AUTO ? '{6, 26, 34} : '{6};
        late = 0;
        @(negedge clk);
        next_raw = 1'b1;
        for (int c = 1; c <= 80; c++) begin
            @(negedge clk);
            if (c == 60) next_raw = 1'b0;
            if (next_pulse === 1'b1) pq.push_back(c);
            if (next_pulse === 1'b1 && c > 66) late++;
            n_tests++;
            if (dut_vec !== mdl_vec) begin
                n_fail++;
                $display("FAIL repeat_model cyc=%0d got=%h exp=%h", c, dut_vec, mdl_vec);
            end
        end
        n_tests++;
        if (pq.size() < ex.size() || (!AUTO && pq.size() != 1)) begin
            n_fail++;
            $display("FAIL repeat_count got=%0d exp_min=%0d", pq.size(), ex.size());
        end else begin
            for (int i = 0; i < ex.size(); i++) begin
                n_tests++;
                if (pq[i] !== ex[i]) begin
                    n_fail++;
                    $display("FAIL repeat_time idx=%0d got=%0d exp=%0d", i, pq[i], ex[i]);
                end
            end
        end
        n_tests++;
        if (late !== 0) begin
            n_fail++;
            $display("FAIL repeat_after_release got=%0d exp=0", late);
        end
    endtask

    task automatic test_random();
        logic [10:0] rv;
        rv = '0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            n_tests++;
            if (dut_vec !== mdl_vec) begin
                n_fail++;
                $display("FAIL random_model cyc=%0d got=%h exp=%h", c, dut_vec, mdl_vec);
            end
            if (c == 300) rst_n = 1'b0;
            if (c == 302) rst_n = 1'b1;
            for (int b = 0; b < 11; b++) begin
                if ($urandom_range(0, 4) == 0) rv[b] = ~rv[b];
            end
            if (c >= 200 && c < 240) rv[10] = 1'b1;
            {prev_raw, next_raw, octave_raw, key_raw} = rv;
        end
        {prev_raw, next_raw, octave_raw, key_raw} = '0;
        idle(10);
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_priority();
        test_octave();
        test_autorepeat();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
